seg_execute_muldiv: RTL
=======================

Name: seg_execute_muldiv

Overview:
- Iterative multiply/divide unit for the MIPS execute stage. It sits beside the single-cycle ALU and owns the HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- A radix-2 FSM runs shift-add multiplication or restoring division over 32 iterations.
- Stalls the pipeline through o_stall whenever an HI/LO access or a new operation arrives while a computation is in flight.

Parameters:
- NB_DATA, 32, operand, HI and LO width.
- NB_MDOP, 3, width of the operation code.
- NB_CNT, 6, iteration counter width; must satisfy 2^NB_CNT > NB_DATA.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  execute stage presents a mul/div/HI/LO instruction this cycle.
- i_op  in  NB_MDOP  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
- i_data_a  in  NB_DATA  rs operand (multiplicand, dividend, or MTHI/MTLO source).
- i_data_b  in  NB_DATA  rt operand (multiplier or divisor).
- i_flush  in  1  synchronous abort of the in-flight operation.
- o_stall  out  1  hold the pipeline; the request is not accepted this cycle.
- o_busy  out  1  FSM is in CALC or FIX.
- o_done  out  1  one-cycle pulse in the cycle HI/LO take the new result.
- o_mf_data  out  NB_DATA  HI for MFHI, LO for MFLO; 0 otherwise. Valid when i_req && !o_stall.

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM goes to IDLE; HI, LO, counter and working registers clear to 0.
  - o_stall=0, o_busy=0, o_done=0.
  - Reset asserted mid-operation discards the operation; HI/LO read 0 afterwards.
- o_stall = i_req && o_busy. It is combinational, so no request is accepted while busy.
- IDLE state:
  - i_req with MULT/MULTU/DIV/DIVU: latch the operands. Signed ops store abs(a) and abs(b) plus a result-sign flag and a dividend-sign flag. Clear the counter and go to CALC.
  - i_req with MTHI/MTLO: write i_data_a to HI or LO at the edge; stay in IDLE.
  - i_req with MFHI/MFLO: o_mf_data is combinational from HI or LO; no state change.
- CALC state, one iteration per cycle:
  - Multiply: if the product LSB is 1, add the multiplicand to the upper half of a 2*NB_DATA accumulator, then shift right by 1.
  - Divide: shift the remainder:quotient pair left by 1, trial-subtract the divisor, and keep the result if it is non-negative, setting the quotient LSB.
  - The counter increments each cycle. After NB_DATA iterations (counter == NB_DATA-1), go to FIX.
- FIX state, one cycle:
  - Apply signs. Signed product is negated when the result-sign flag is set. Signed quotient is negated when operand signs differ (truncation toward zero). Remainder takes the dividend's sign.
  - Write HI/LO: multiply gives HI=upper, LO=lower; divide gives HI=remainder, LO=quotient.
  - Pulse o_done and return to IDLE.
- Latency: accepted in cycle 0, CALC occupies cycles 1..32, FIX is cycle 33, and HI/LO are valid from cycle 34. o_busy is high for cycles 1..33.
- Divide by zero: no trap. HI = a (original signed value), LO = all ones.
- INT_MIN / -1 (DIV): LO = 0x80000000, HI = 0, with no special casing.
- i_flush:
  - While busy: return to IDLE next edge, HI/LO unchanged, no o_done.
  - In IDLE with i_req: the request is ignored, including MT writes.
- MF/MT request on the FIX cycle: stalled. It is accepted the next cycle and sees the new HI/LO.
- MULTU/DIVU treat operands as unsigned, with no abs or negate.

Decomposition:
- Shared package/header holds:
  - the op codes (MD_MULT..MD_MTLO);
  - the FSM state encodings (ST_IDLE=2'b00, ST_CALC=2'b01, ST_FIX=2'b10);
  - the NB_DATA and NB_MDOP defaults.
- One natural sub-module, seg_execute_muldiv_step: the combinational single-iteration datapath (shift-add or trial-subtract) selected by a mul/div bit. The top module keeps the FSM, counter and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> o_done at cycle 33, then HI=0xFFFFFFFF, LO=0xFFFFFFEB; o_busy high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=7, b=0 -> HI=7, LO=0xFFFFFFFF.
- MFLO issued the cycle after starting DIV 100/7 -> o_stall=1 for 33 cycles, then o_mf_data=14 with o_stall=0; a following MFHI returns 2.
- MTHI 0x12345678, then MULT 5*6 with i_flush at cycle 10 -> no o_done, FSM back in IDLE next cycle, HI=0x12345678, LO unchanged.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. i_rst_n pulsed low at cycle 15 of a MULT -> all outputs 0 immediately, HI=LO=0.

Source files
------------

// File: rtl/seg_execute_muldiv_pkg.sv
// Shared constants for the execute-stage multiply/divide unit:
// op codes, FSM state encodings and default widths.
package seg_execute_muldiv_pkg;

    localparam int DEF_NB_DATA = 32;
    localparam int DEF_NB_MDOP = 3;
    localparam int DEF_NB_CNT  = 6;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MFHI  = 3'b100,
        MD_MFLO  = 3'b101,
        MD_MTHI  = 3'b110,
        MD_MTLO  = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_t;

endpackage

// File: rtl/seg_execute_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step
// over a double-width accumulator.
module seg_execute_muldiv_step #(
    parameter int NB_DATA = 32
) (
    input  logic                   is_div,
    input  logic [2*NB_DATA-1:0]   acc,
    input  logic [NB_DATA-1:0]     opnd,
    output logic [2*NB_DATA-1:0]   acc_next
);

    logic [NB_DATA:0] sum;
    logic [NB_DATA:0] part;
    logic [NB_DATA:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + {1'b0, opnd};
        // partial remainder after the left shift, carry bit kept
        part     = acc[2*NB_DATA-1:NB_DATA-1];
        diff     = part - {1'b0, opnd};
        acc_next = '0;
        if (is_div) begin
            if (diff[NB_DATA])
                acc_next = {part[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b0};
            else
                acc_next = {diff[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b1};
        end else if (acc[0]) begin
            acc_next = {sum, acc[NB_DATA-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*NB_DATA-1:1]};
        end
    end

endmodule

// File: rtl/seg_execute_muldiv.sv
// Iterative multiply/divide unit owning HI/LO; stalls the pipeline
// while a 32-iteration computation is in flight.
module seg_execute_muldiv
    import seg_execute_muldiv_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_MDOP = DEF_NB_MDOP,
    parameter int NB_CNT  = DEF_NB_CNT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req,
    input  logic [NB_MDOP-1:0] i_op,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic               i_flush,
    output logic               o_stall,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_mf_data
);

    localparam logic [NB_CNT-1:0] LAST = NB_CNT'(NB_DATA - 1);

    md_state_t            state;
    logic [NB_CNT-1:0]    cnt;
    logic [NB_DATA-1:0]   hi;
    logic [NB_DATA-1:0]   lo;
    logic [2*NB_DATA-1:0] acc;
    logic [NB_DATA-1:0]   opnd;
    logic                 is_div;
    logic                 res_neg;
    logic                 dvd_neg;
    logic                 div_zero;

    logic [2*NB_DATA-1:0] acc_next;
    logic                 busy;
    logic                 op_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [NB_DATA-1:0]   a_mag;
    logic [NB_DATA-1:0]   b_mag;
    logic [2*NB_DATA-1:0] prod;
    logic [NB_DATA-1:0]   quo;
    logic [NB_DATA-1:0]   rem;
    logic [NB_DATA-1:0]   res_hi;
    logic [NB_DATA-1:0]   res_lo;

    seg_execute_muldiv_step #(
        .NB_DATA (NB_DATA)
    ) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_next)
    );

    assign busy    = (state != ST_IDLE);
    assign o_busy  = busy;
    assign o_stall = i_req && busy;
    assign o_done  = (state == ST_FIX) && !i_flush;

    always_comb begin
        o_mf_data = '0;
        if (i_req) begin
            if (i_op == MD_MFHI)
                o_mf_data = hi;
            else if (i_op == MD_MFLO)
                o_mf_data = lo;
        end
    end

    // MULT and DIV have op[0] clear; those work on magnitudes
    always_comb begin
        op_signed = !i_op[0];
        a_neg     = op_signed && i_data_a[NB_DATA-1];
        b_neg     = op_signed && i_data_b[NB_DATA-1];
        a_mag     = a_neg ? ({NB_DATA{1'b0}} - i_data_a) : i_data_a;
        b_mag     = b_neg ? ({NB_DATA{1'b0}} - i_data_b) : i_data_b;
    end

    // A zero divisor leaves the quotient at all ones, never negated
    always_comb begin
        prod   = res_neg ? ({2*NB_DATA{1'b0}} - acc) : acc;
        quo    = acc[NB_DATA-1:0];
        rem    = acc[2*NB_DATA-1:NB_DATA];
        if (res_neg && !div_zero)
            quo = {NB_DATA{1'b0}} - quo;
        if (dvd_neg)
            rem = {NB_DATA{1'b0}} - rem;
        res_hi = is_div ? rem : prod[2*NB_DATA-1:NB_DATA];
        res_lo = is_div ? quo : prod[NB_DATA-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            res_neg  <= 1'b0;
            dvd_neg  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_req && !i_flush) begin
                        if (!i_op[NB_MDOP-1]) begin
                            is_div   <= i_op[1];
                            res_neg  <= a_neg ^ b_neg;
                            dvd_neg  <= a_neg;
                            div_zero <= (i_data_b == '0);
                            cnt      <= '0;
                            state    <= ST_CALC;
                            if (i_op[1]) begin
                                acc  <= {{NB_DATA{1'b0}}, a_mag};
                                opnd <= b_mag;
                            end else begin
                                acc  <= {{NB_DATA{1'b0}}, b_mag};
                                opnd <= a_mag;
                            end
                        end else if (i_op == MD_MTHI) begin
                            hi <= i_data_a;
                        end else if (i_op == MD_MTLO) begin
                            lo <= i_data_a;
                        end
                    end
                end
                ST_CALC: begin
                    if (i_flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + NB_CNT'(1);
                        if (cnt == LAST)
                            state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!i_flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
